// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit and receive paths: FSM encoding,
// parity selection and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and data-bit counter for the UART transmitter.
// ser_bit is the data bit currently on the line; ser_done flags the last one.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = data;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = shift_q >> 1;
      cnt_d   = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_bit  = shift_q[0];
  assign ser_done = (cnt_q == CntW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// stop bit. One bit per clck (baud) cycle; tx_out and busy decode registered state only.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  uart_state_e state_q, state_d;

  logic load;
  logic shift_en;
  logic ser_bit;
  logic ser_done;
  logic par_en_q;
  logic par_bit_q;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clck    (clck),
    .rst     (rst),
    .load    (load),
    .shift_en(shift_en),
    .data    (p_data),
    .ser_bit (ser_bit),
    .ser_done(ser_done)
  );

  // The state register names what is on the line after each edge.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: state_d = DATA;
      DATA: begin
        shift_en = 1'b1;
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        par_en_q  <= par_en;
        par_bit_q <= (^p_data) ^ (par_typ == PAR_ODD);
      end
    end
  end

  always_comb begin
    tx_out = IDLE_LEVEL;
    unique case (state_q)
      START:   tx_out = START_BIT;
      DATA:    tx_out = ser_bit;
      PARITY:  tx_out = par_bit_q;
      STOP:    tx_out = STOP_BIT;
      default: tx_out = IDLE_LEVEL;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected {tx_out, busy} samples are queued
// when a request is driven and compared one per cycle on the falling edge.
module tb_uart_tx;

  logic       clck;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];

  uart_tx #(
    .DATA_WIDTH(8)
  ) dut (
    .clck      (clck),
    .rst       (rst),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .tx_out    (tx_out),
    .busy      (busy)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;

  // Expected line samples, one per cycle starting just after the acceptance edge.
  function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
    exp_q.push_back(2'b01);
    for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
    if (pe) exp_q.push_back({(^d) ^ pt, 1'b1});
    exp_q.push_back(2'b11);
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b10);
  endfunction

  task automatic test_reset();
    logic [1:0] exp;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({tx_out, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_immediate: got tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clck);
      checks++;
      if ({tx_out, busy} !== 2'b10) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got tx=%b busy=%b, want tx=1 busy=0", i, tx_out, busy);
      end
    end
    rst = 1'b1;
    push_idle(3);
    @(negedge clck);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL reset_idle: got tx=%b busy=%b, want tx=%b busy=%b",
                 tx_out, busy, exp[1], exp[0]);
      end
      @(negedge clck);
    end
  endtask

  task automatic test_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input string name);
    logic [1:0] exp;
    int idx;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    push_frame(d, pe, pt);
    push_idle(1);
    @(negedge clck);
    data_valid = 1'b0;
    idx = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL %s[%0d]: got tx=%b busy=%b, want tx=%b busy=%b",
                 name, idx, tx_out, busy, exp[1], exp[0]);
      end
      idx++;
      @(negedge clck);
    end
  endtask

  task automatic test_latched_inputs();
    logic [1:0] exp;
    int idx;
    p_data     = 8'h07;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    push_frame(8'h07, 1'b1, 1'b0);
    push_idle(4);
    @(negedge clck);
    data_valid = 1'b0;
    idx = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL latched[%0d]: got tx=%b busy=%b, want tx=%b busy=%b",
                 idx, tx_out, busy, exp[1], exp[0]);
      end
      if (idx == 3) begin
        p_data     = 8'hFF;
        par_en     = 1'b0;
        par_typ    = 1'b1;
        data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      idx++;
      @(negedge clck);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    int idx;
    p_data     = 8'h3C;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0);
    push_idle(1);
    push_frame(8'h3C, 1'b0, 1'b0);
    push_idle(2);
    @(negedge clck);
    idx = 0;
    while (exp_q.size() > 0) begin
      // Drop the request during the second stop bit so no third frame starts.
      if (exp_q.size() == 3) data_valid = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got tx=%b busy=%b, want tx=%b busy=%b",
                 idx, tx_out, busy, exp[1], exp[0]);
      end
      idx++;
      @(negedge clck);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] exp;
    int idx;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    push_frame(8'h00, 1'b0, 1'b0);
    @(negedge clck);
    data_valid = 1'b0;
    // Samples 0..4 are start bit and data bits 0..3; reset lands in bit 3.
    for (idx = 0; idx < 5; idx++) begin
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL pre_abort[%0d]: got tx=%b busy=%b, want tx=%b busy=%b",
                 idx, tx_out, busy, exp[1], exp[0]);
      end
      if (idx < 4) @(negedge clck);
    end
    exp_q.delete();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({tx_out, busy} !== 2'b10) begin
      errors++;
      $display("FAIL abort_async: got tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
    end
    @(negedge clck);
    rst = 1'b1;
    @(negedge clck);
    checks++;
    if ({tx_out, busy} !== 2'b10) begin
      errors++;
      $display("FAIL abort_idle: got tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
    end
  endtask

  initial begin
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    test_reset();
    test_frame(8'hA5, 1'b0, 1'b0, "a5_nopar");
    test_frame(8'hA5, 1'b1, 1'b0, "a5_even");
    test_frame(8'hA5, 1'b1, 1'b1, "a5_odd");
    test_latched_inputs();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame(8'h81, 1'b0, 1'b0, "post_reset_81");
    test_frame(8'h5B, 1'b1, 1'b1, "5b_odd");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
